dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- MEM-stage data-memory access sequencer between the EX/MEM pipeline register outputs and the data-memory bus port.
- Captures one load/store request, runs a req/ack handshake, and raises dm_stall until the access completes.
- Aligns and sign-/zero-extends load data, holds the result while other stalls freeze the pipeline, and enforces a bus timeout.

Parameters:
TIMEOUT, 255, max BUSY cycles without bus_ack before abort with error (1..65535)
CNT_W, 16, timeout counter width; must hold TIMEOUT

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_read  input  1  MEM-stage load request
mem_write  input  1  MEM-stage store request
mem_web  input  4  store byte write enables, active-low (4'hf = no write)
mem_addr  input  32  effective address
mem_wdata  input  32  store data, already lane-shifted
mem_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
other_stall  input  1  any non-DM stall (im_stall | CSR_stall)
flush  input  1  synchronous pipeline flush (CSR_reset)
bus_req  output  1  bus request, registered
bus_we  output  1  1 = write, registered
bus_web  output  4  byte enables to bus, active-low, registered
bus_addr  output  32  registered address
bus_wdata  output  32  registered write data
bus_ack  input  1  transfer complete; bus_rdata valid in same cycle
bus_rdata  input  32  read data
dm_stall  output  1  freeze pipeline
load_data  output  32  extended load result
load_valid  output  1  load_data valid for current MEM instruction
bus_err  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, any state): state=IDLE; bus_req=0, bus_we=0, bus_web=4'hf, bus_addr=0, bus_wdata=0, load_data=0, load_valid=0, bus_err=0, counter=0, discard=0. dm_stall=0 (no request present).
- States:
  - IDLE
  - BUSY: bus_req=1
  - DONE: result held
- IDLE:
  - Request = (mem_read | mem_write) & ~flush.
  - dm_stall = request, combinational.
  - On request: capture addr/wdata/funct3/web into the bus registers. bus_we = mem_write; write wins if both are set. For reads, bus_web = 4'hf. Go to BUSY; counter cleared.
- BUSY:
  - bus_req=1; outputs stable; dm_stall=1.
  - Counter increments each cycle without ack.
  - bus_ack: bus_req drops next edge.
    - Read: load_data = extract(bus_rdata); load_valid=1.
    - Write: load_valid=0.
    - Then DONE, or IDLE if discard is set.
  - Counter reaching TIMEOUT without ack: bus_err pulses 1 cycle; load_data=0; load_valid=0; go to DONE (or IDLE if discard).
- DONE:
  - dm_stall=0.
  - If other_stall=0: the pipeline advances this edge; go to IDLE; load_valid clears.
  - If other_stall=1: stay in DONE, hold load_data/load_valid, never re-issue.
- Load extraction (byte offset o = addr[1:0]):
  - LB/LBU: byte o, sign- or zero-extended.
  - LH/LHU: half addr[1], sign- or zero-extended.
  - LW: full word.
  - Other funct3: full word.
- Minimum latency: request cycle plus BUSY-with-ack cycle = 2 dm_stall cycles; data valid in the DONE cycle.
- Flush:
  - In IDLE: no issue, dm_stall=0.
  - In BUSY: the transaction is not aborted. discard=1, dm_stall stays 1 until ack/timeout, then IDLE with load_valid=0.
  - In DONE: go to IDLE, load_valid=0.
  - discard is cleared on entering IDLE.
- Simultaneous flush and ack in BUSY: treated as discarded.
- bus_ack in IDLE/DONE is ignored.

Test Plan:
- LW addr 0x100, ack after 3 BUSY cycles, rdata 0xDEADBEEF -> dm_stall high 4 cycles, DONE load_data=0xDEADBEEF, load_valid=1, single bus_req burst.
- LB addr 0x203, rdata 0x80112233 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x202 -> 0xFFFF8011.
- SB addr 0x301, mem_web=4'b1101, wdata 0x0000AB00, ack 1st BUSY cycle -> bus_we=1, bus_web=4'b1101, bus_wdata=0x0000AB00, load_valid=0, 2 stall cycles.
- LW completes while other_stall=1 for 5 cycles -> stays DONE, exactly one bus_req transaction, load_data held, returns to IDLE the cycle other_stall falls.
- flush asserted mid-BUSY, ack 2 cycles later -> bus_req held until ack, load_valid never 1, IDLE after ack; a new request the next cycle issues normally.
- TIMEOUT=4, no ack -> bus_err pulse after 4 BUSY cycles, load_data=0; reset asserted mid-BUSY -> all outputs at reset values immediately.

Source files
------------

// File: rtl/dm_access_ctrl_if.sv
// Data-memory bus port between the MEM-stage access sequencer (master) and memory (slave).
// Request side is registered by the master; bus_rdata is valid in the cycle bus_ack is high.
interface dm_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_web;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_web,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_web,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues one load/store per request, stalls the
// pipeline until ack or timeout, and holds the extended load result while other stalls persist.
module dm_access_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_read_i,
    input  logic                     mem_write_i,
    input  logic [3:0]               mem_web_i,
    input  logic [31:0]              mem_addr_i,
    input  logic [31:0]              mem_wdata_i,
    input  logic [2:0]               mem_funct3_i,
    input  logic                     other_stall_i,
    input  logic                     flush_i,
    dm_access_ctrl_if.master         bus,
    output logic                     dm_stall_o,
    output logic [31:0]              load_data_o,
    output logic                     load_valid_o,
    output logic                     bus_err_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_web_q, bus_web_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        discard_q, discard_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             request;
    logic             drop;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b100:  extract = {24'h0, b};
            3'b101:  extract = {16'h0, h};
            default: extract = w;
        endcase
    endfunction

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign request = (mem_read_i | mem_write_i) & ~flush_i;
    // A flush arriving together with the ack/timeout still discards the result.
    assign drop    = discard_q | flush_i;

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_web_d    = bus_web_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        funct3_d     = funct3_q;
        load_data_d  = load_data_q;
        load_valid_d = load_valid_q;
        bus_err_d    = 1'b0;
        cnt_d        = cnt_q;
        discard_d    = discard_q;
        dm_stall_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                discard_d  = 1'b0;
                dm_stall_o = request;
                if (request) begin
                    bus_req_d    = 1'b1;
                    bus_we_d     = mem_write_i;
                    bus_web_d    = mem_write_i ? mem_web_i : 4'hf;
                    bus_addr_d   = mem_addr_i;
                    bus_wdata_d  = mem_wdata_i;
                    funct3_d     = mem_funct3_i;
                    load_valid_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                dm_stall_o = 1'b1;
                if (flush_i) discard_d = 1'b1;
                if (bus.bus_ack) begin
                    bus_req_d = 1'b0;
                    if (drop) begin
                        load_valid_d = 1'b0;
                        discard_d    = 1'b0;
                        state_d      = StIdle;
                    end else begin
                        if (!bus_we_q) begin
                            load_data_d  = extract(bus.bus_rdata, bus_addr_q[1:0], funct3_q);
                            load_valid_d = 1'b1;
                        end else begin
                            load_valid_d = 1'b0;
                        end
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        bus_req_d    = 1'b0;
                        bus_err_d    = 1'b1;
                        load_data_d  = '0;
                        load_valid_d = 1'b0;
                        discard_d    = 1'b0;
                        state_d      = drop ? StIdle : StDone;
                    end
                end
            end
            StDone: begin
                if (flush_i || !other_stall_i) begin
                    load_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_web_q    <= 4'hf;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            funct3_q     <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            cnt_q        <= '0;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_web_q    <= bus_web_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            funct3_q     <= funct3_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
            cnt_q        <= cnt_d;
            discard_q    <= discard_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_web   = bus_web_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign load_data_o   = load_data_q;
    assign load_valid_o  = load_valid_q;
    assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: loads/stores, extension, held results, flush, timeout, reset.
module tb_dm_access_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_read, mem_write, other_stall, flush;
    logic [3:0]  mem_web;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic        dm_stall, load_valid, bus_err;
    logic [31:0] load_data;

    int n_vec = 0;
    int n_err = 0;
    int n_req = 0;
    int n_stall = 0;
    int n_valid = 0;
    logic req_prev = 1'b0;

    dm_access_ctrl_if bus ();

    dm_access_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read_i    (mem_read),
        .mem_write_i   (mem_write),
        .mem_web_i     (mem_web),
        .mem_addr_i    (mem_addr),
        .mem_wdata_i   (mem_wdata),
        .mem_funct3_i  (mem_funct3),
        .other_stall_i (other_stall),
        .flush_i       (flush),
        .bus           (bus),
        .dm_stall_o    (dm_stall),
        .load_data_o   (load_data),
        .load_valid_o  (load_valid),
        .bus_err_o     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.bus_req && !req_prev) n_req++;
        req_prev = bus.bus_req;
        if (dm_stall) n_stall++;
        if (load_valid) n_valid++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd,
                        input int nbusy);
        cyc();
        mem_read = 1'b1; mem_addr = a; mem_funct3 = f3;
        #1;
        chk("ld_req_stall", {31'h0, dm_stall}, 32'd1);
        for (int i = 1; i <= nbusy; i++) begin
            cyc();
            if (i == nbusy) begin
                bus.bus_ack = 1'b1; bus.bus_rdata = rd;
            end
            #1;
            chk("ld_busy_req", {31'h0, bus.bus_req}, 32'd1);
        end
        cyc();
        bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        #1;
    endtask

    task automatic idle_next();
        cyc();
        mem_read = 1'b0; mem_write = 1'b0; mem_web = 4'hf;
        #1;
        chk("idle_valid", {31'h0, load_valid}, 32'd0);
        chk("idle_stall", {31'h0, dm_stall}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'h0, bus.bus_req}, 32'd0);
        chk({tag, "_we"},    {31'h0, bus.bus_we}, 32'd0);
        chk({tag, "_web"},   {28'h0, bus.bus_web}, 32'hf);
        chk({tag, "_addr"},  bus.bus_addr, 32'h0);
        chk({tag, "_wdata"}, bus.bus_wdata, 32'h0);
        chk({tag, "_ldata"}, load_data, 32'h0);
        chk({tag, "_valid"}, {31'h0, load_valid}, 32'd0);
        chk({tag, "_err"},   {31'h0, bus_err}, 32'd0);
        chk({tag, "_stall"}, {31'h0, dm_stall}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_web = 4'hf;
        mem_addr = '0; mem_wdata = '0; mem_funct3 = 3'b010;
        other_stall = 1'b0; flush = 1'b0;
        bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        cyc();
        chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;

        // LW, ack in third BUSY cycle
        n_stall = 0; n_req = 0;
        load(32'h100, 3'b010, 32'hDEADBEEF, 3);
        chk("lw_addr_hold", bus.bus_addr, 32'h100);
        chk("lw_req_drop", {31'h0, bus.bus_req}, 32'd0);
        chk("lw_data", load_data, 32'hDEADBEEF);
        chk("lw_valid", {31'h0, load_valid}, 32'd1);
        chk("lw_done_stall", {31'h0, dm_stall}, 32'd0);
        chk("lw_stall_cycles", n_stall, 32'd4);
        chk("lw_req_bursts", n_req, 32'd1);
        idle_next();

        // byte/half extraction
        load(32'h203, 3'b000, 32'h80112233, 1);
        chk("lb_data", load_data, 32'hFFFFFF80);
        idle_next();
        load(32'h203, 3'b100, 32'h80112233, 1);
        chk("lbu_data", load_data, 32'h00000080);
        idle_next();
        load(32'h202, 3'b001, 32'h80112233, 1);
        chk("lh_data", load_data, 32'hFFFF8011);
        idle_next();
        load(32'h200, 3'b101, 32'h80112233, 1);
        chk("lhu_data", load_data, 32'h00002233);
        idle_next();
        load(32'h201, 3'b000, 32'h80112233, 2);
        chk("lb_off1", load_data, 32'h00000022);
        idle_next();

        // SB, ack in first BUSY cycle
        n_stall = 0;
        cyc();
        mem_write = 1'b1; mem_web = 4'b1101; mem_addr = 32'h301; mem_wdata = 32'h0000AB00;
        #1;
        chk("sb_req_stall", {31'h0, dm_stall}, 32'd1);
        cyc();
        bus.bus_ack = 1'b1;
        #1;
        chk("sb_req", {31'h0, bus.bus_req}, 32'd1);
        chk("sb_we", {31'h0, bus.bus_we}, 32'd1);
        chk("sb_web", {28'h0, bus.bus_web}, 32'hd);
        chk("sb_wdata", bus.bus_wdata, 32'h0000AB00);
        chk("sb_addr", bus.bus_addr, 32'h301);
        cyc();
        bus.bus_ack = 1'b0;
        #1;
        chk("sb_valid", {31'h0, load_valid}, 32'd0);
        chk("sb_stall_cycles", n_stall, 32'd2);
        idle_next();

        // LW finishing under other_stall
        n_req = 0;
        load(32'h400, 3'b010, 32'h12345678, 1);
        other_stall = 1'b1;
        chk("os_valid1", {31'h0, load_valid}, 32'd1);
        for (int i = 2; i <= 5; i++) begin
            cyc();
            #1;
            chk("os_hold_valid", {31'h0, load_valid}, 32'd1);
            chk("os_hold_data", load_data, 32'h12345678);
            chk("os_no_req", {31'h0, bus.bus_req}, 32'd0);
            chk("os_no_stall", {31'h0, dm_stall}, 32'd0);
        end
        cyc();
        other_stall = 1'b0;
        #1;
        chk("os_last_valid", {31'h0, load_valid}, 32'd1);
        idle_next();
        chk("os_req_bursts", n_req, 32'd1);

        // flush while idle suppresses the request
        cyc();
        mem_read = 1'b1; flush = 1'b1;
        #1;
        chk("fli_stall", {31'h0, dm_stall}, 32'd0);
        cyc();
        mem_read = 1'b0; flush = 1'b0;
        #1;
        chk("fli_no_req", {31'h0, bus.bus_req}, 32'd0);

        // flush mid-BUSY, ack two cycles later, then a fresh request
        cyc();
        mem_read = 1'b1; mem_addr = 32'h500; mem_funct3 = 3'b010; n_valid = 0;
        #1;
        cyc();
        flush = 1'b1; mem_read = 1'b0;
        #1;
        chk("flb_stall1", {31'h0, dm_stall}, 32'd1);
        cyc();
        flush = 1'b0;
        #1;
        chk("flb_req2", {31'h0, bus.bus_req}, 32'd1);
        chk("flb_stall2", {31'h0, dm_stall}, 32'd1);
        cyc();
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h11111111;
        #1;
        chk("flb_req3", {31'h0, bus.bus_req}, 32'd1);
        cyc();
        bus.bus_ack = 1'b0; mem_read = 1'b1; mem_addr = 32'h600;
        #1;
        chk("flb_idle_req", {31'h0, bus.bus_req}, 32'd0);
        chk("flb_idle_valid", {31'h0, load_valid}, 32'd0);
        chk("flb_new_stall", {31'h0, dm_stall}, 32'd1);
        cyc();
        #1;
        chk("flb_new_req", {31'h0, bus.bus_req}, 32'd1);
        chk("flb_new_addr", bus.bus_addr, 32'h600);
        chk("flb_never_valid", n_valid, 32'd0);
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h0BADF00D;
        cyc();
        bus.bus_ack = 1'b0;
        #1;
        chk("flb_new_data", load_data, 32'h0BADF00D);
        chk("flb_new_valid", {31'h0, load_valid}, 32'd1);
        idle_next();

        // asynchronous reset mid-BUSY
        cyc();
        mem_write = 1'b1; mem_web = 4'h0; mem_addr = 32'h800; mem_wdata = 32'hCAFEF00D;
        #1;
        cyc();
        #1;
        chk("rb_req", {31'h0, bus.bus_req}, 32'd1);
        chk("rb_wdata", bus.bus_wdata, 32'hCAFEF00D);
        #1;
        reset = 1'b1; mem_write = 1'b0; mem_web = 4'hf;
        #1;
        chk_reset_vals("rb");
        @(negedge clk);
        reset = 1'b0;

        // timeout after four BUSY cycles without ack
        load(32'h704, 3'b010, 32'h5A5A5A5A, 1);
        chk("to_pre_data", load_data, 32'h5A5A5A5A);
        idle_next();
        cyc();
        mem_read = 1'b1; mem_addr = 32'h700; mem_funct3 = 3'b010;
        #1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            chk("to_busy_req", {31'h0, bus.bus_req}, 32'd1);
            chk("to_busy_err", {31'h0, bus_err}, 32'd0);
        end
        cyc();
        #1;
        chk("to_err", {31'h0, bus_err}, 32'd1);
        chk("to_req", {31'h0, bus.bus_req}, 32'd0);
        chk("to_data", load_data, 32'h0);
        chk("to_valid", {31'h0, load_valid}, 32'd0);
        chk("to_stall", {31'h0, dm_stall}, 32'd0);
        idle_next();
        chk("to_err_pulse", {31'h0, bus_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
